stack_unit: RTL and testbench
=============================

STACK_UNIT -- requirements
Module: stack_unit

Interface
REQ-001 The block SHALL have parameter STACK_TOP, 32'd1023, highest stack address and reset value of SP.
REQ-002 The block SHALL have parameter STACK_LIMIT, 32'd768, lowest usable stack address.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port start  input  1  one-cycle request to execute StackOp.
REQ-006 The block SHALL have port StackOp  input  3  opcode: 001 PUSH, 010 POP, 011 CALL, 100 RET.
REQ-007 The block SHALL have port PCin  input  32  current PC; CALL pushes PCin+1.
REQ-008 The block SHALL have port regval  input  32  data pushed by PUSH.
REQ-009 The block SHALL have port mem_rdata  input  32  data memory read data.
REQ-010 The block SHALL have port mem_ready  input  1  memory completes the pending access this cycle.
REQ-011 The block SHALL have port mem_req, mem_we  output  1 each  access request; write enable.
REQ-012 The block SHALL have port mem_addr, mem_wdata  output  32 each  access address; write data.
REQ-013 The block SHALL have port LMD  output  32  last value read by POP/RET (return address for PC_control).
REQ-014 The block SHALL have port SP  output  32  stack pointer (next free slot).
REQ-015 The block SHALL have port busy, done, err  output  1 each  in progress; one-cycle completion pulse; one-cycle error pulse coincident with done.

Function
REQ-016 FSM SHALL have states IDLE, ACCESS, DONE; busy=1 in ACCESS and DONE.
REQ-017 Stack SHALL grow downward; SP points to next free slot; empty when SP==STACK_TOP; full when SP==STACK_LIMIT-1.
REQ-018 In IDLE with start=1 and a valid opcode, the block SHALL latch operands and enter ACCESS next cycle.
REQ-019 PUSH/CALL SHALL write mem[SP] with regval / PCin+1 (32-bit wrap) and, on completion, set SP<=SP-1.
REQ-020 POP/RET SHALL read mem[SP+1] and, on completion, set LMD<=mem_rdata and SP<=SP+1.
REQ-021 In ACCESS, mem_req SHALL be 1 and mem_addr/mem_we/mem_wdata SHALL stay stable until a cycle with mem_ready=1.
REQ-022 The mem_ready=1 cycle in ACCESS SHALL complete the access; mem_req SHALL be 0 next cycle and the state SHALL be DONE.
REQ-023 DONE SHALL last exactly one cycle with done=1, then return to IDLE; minimum latency start->done is 2 cycles at zero wait states.
REQ-024 PUSH/CALL when full, or POP/RET when empty, SHALL cause IDLE->DONE directly with err=1, no memory access, SP and LMD unchanged.
REQ-025 start SHALL be ignored outside IDLE; start with opcode 000 or 101-111 SHALL be ignored (no done, no err).
REQ-026 mem_ready outside ACCESS SHALL be ignored.
REQ-027 mem_req SHALL be 0 whenever state is not ACCESS.
REQ-028 mem_we SHALL be 0 whenever mem_req is 0.
REQ-029 SP arithmetic SHALL be 32-bit unsigned.
REQ-030 SP SHALL never leave [STACK_LIMIT-1, STACK_TOP].

Reset
REQ-031 On rst=1 at a clock edge the block SHALL set state IDLE, SP=STACK_TOP, LMD=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, done=0, err=0, busy=0.
REQ-032 rst SHALL override start and mem_ready in the same cycle.
REQ-033 rst during ACCESS SHALL abandon the access with no SP or LMD update.

Verification
REQ-034 Reset, then PUSH regval=0xDEADBEEF, mem_ready=1 at once: mem_addr=1023, mem_we=1; done on the 2nd cycle after start; SP=1022.
REQ-035 Continuing REQ-034, POP with mem_rdata=0xDEADBEEF and 3 wait cycles: mem_addr=1023 held 4 cycles; LMD=0xDEADBEEF; SP=1023.
REQ-036 CALL PCin=40, then RET returning the stored word: mem_wdata=41 at addr 1023; after RET LMD=41, SP=1023.
REQ-037 POP with SP=1023: done=err=1 next cycle; mem_req never asserts; SP=1023.
REQ-038 256 PUSHes fill the stack to SP=767; 257th PUSH: err=1, no mem_req, SP=767.
REQ-039 rst during ACCESS of a PUSH at SP=1020: next cycle mem_req=0, SP=1023, no done; start during busy is ignored.

Source files
------------

// File: rtl/stack_unit.sv
// Hardware stack engine: PUSH/POP/CALL/RET against a single-port data memory
// with a ready handshake. The stack grows downward and SP points at the next free slot.
`timescale 1ns/1ps
module stack_unit #(
  parameter logic [31:0] STACK_TOP   = 32'd1023,
  parameter logic [31:0] STACK_LIMIT = 32'd768
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  StackOp,
  input  logic [31:0] PCin,
  input  logic [31:0] regval,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [31:0] LMD,
  output logic [31:0] SP,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [2:0] OP_PUSH = 3'b001;
  localparam logic [2:0] OP_POP  = 3'b010;
  localparam logic [2:0] OP_CALL = 3'b011;
  localparam logic [2:0] OP_RET  = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_sp;
  logic [31:0] r_lmd;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_we;
  logic        r_err;

  logic        w_op_valid;
  logic        w_op_write;
  logic        w_full;
  logic        w_empty;
  logic        w_op_err;
  logic        w_accept;
  logic [31:0] w_wdata;

  // Unsigned 32-bit stack-pointer steps; the range guard lives in w_op_err.
  function automatic logic [31:0] f_sp_dec(input logic [31:0] sp);
    return sp - 32'd1;
  endfunction

  function automatic logic [31:0] f_sp_inc(input logic [31:0] sp);
    return sp + 32'd1;
  endfunction

  always_comb begin
    w_op_valid = (StackOp == OP_PUSH) || (StackOp == OP_POP) ||
                 (StackOp == OP_CALL) || (StackOp == OP_RET);
    w_op_write = (StackOp == OP_PUSH) || (StackOp == OP_CALL);
    w_full     = (r_sp == STACK_LIMIT - 32'd1);
    w_empty    = (r_sp == STACK_TOP);
    w_op_err   = w_op_write ? w_full : w_empty;
    w_accept   = (r_state == S_IDLE) && start && w_op_valid;
    w_wdata    = (StackOp == OP_CALL) ? (PCin + 32'd1) : regval;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = w_op_err ? S_DONE : S_ACCESS;
      S_ACCESS: if (mem_ready) w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sp    <= STACK_TOP;
      r_lmd   <= 32'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        // Operands are frozen here so the bus stays stable through wait states.
        r_err   <= w_op_err;
        r_we    <= w_op_write;
        r_addr  <= w_op_write ? r_sp : f_sp_inc(r_sp);
        r_wdata <= w_op_write ? w_wdata : 32'd0;
      end
      if ((r_state == S_ACCESS) && mem_ready) begin
        if (r_we) begin
          r_sp <= f_sp_dec(r_sp);
        end else begin
          r_sp  <= f_sp_inc(r_sp);
          r_lmd <= mem_rdata;
        end
      end
    end
  end

  always_comb begin
    mem_req   = (r_state == S_ACCESS);
    mem_we    = mem_req && r_we;
    mem_addr  = r_addr;
    mem_wdata = r_wdata;
    LMD       = r_lmd;
    SP        = r_sp;
    busy      = (r_state != S_IDLE);
    done      = (r_state == S_DONE);
    err       = done && r_err;
  end

endmodule

// File: tb/tb_stack_unit.sv
// Scoreboard bench for stack_unit: stimulus queues expected memory accesses and
// completions; a memory responder and a completion monitor pop and compare them.
`timescale 1ns/1ps
module tb_stack_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  StackOp;
  logic [31:0] PCin;
  logic [31:0] regval;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] LMD;
  logic [31:0] SP;
  logic        busy;
  logic        done;
  logic        err;

  stack_unit #(.STACK_TOP(32'd1023), .STACK_LIMIT(32'd768)) dut (
    .clk(clk), .rst(rst), .start(start), .StackOp(StackOp), .PCin(PCin),
    .regval(regval), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .LMD(LMD), .SP(SP), .busy(busy), .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [31:0] sp;
    logic [31:0] lmd;
  } done_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } acc_t;

  done_t       dq[$];
  acc_t        mq[$];
  logic [31:0] mem [0:1023];
  int          checks   = 0;
  int          failures = 0;
  int          wait_n   = 0;
  int          wcnt     = 0;
  logic        spurious = 1'b0;
  logic        have_prev = 1'b0;
  logic [31:0] prev_addr;
  logic [31:0] prev_wdata;
  logic        prev_we;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  function automatic void exp_mem(input logic [31:0] a, input logic we, input logic [31:0] d);
    acc_t e;
    e.addr = a; e.we = we; e.wdata = d;
    mq.push_back(e);
  endfunction

  function automatic void exp_done(input logic e_err, input logic [31:0] sp, input logic [31:0] lmd);
    done_t e;
    e.err = e_err; e.sp = sp; e.lmd = lmd;
    dq.push_back(e);
  endfunction

  // Memory responder and access monitor: inserts wait_n wait states per access.
  always @(negedge clk) begin
    acc_t e;
    if (mem_req) begin
      if (have_prev) begin
        chk("addr_stable", mem_addr, prev_addr);
        chk("we_stable", {31'd0, mem_we}, {31'd0, prev_we});
        chk("wdata_stable", mem_wdata, prev_wdata);
      end
      if (wcnt >= wait_n) begin
        mem_ready = 1'b1;
        wcnt = 0;
        have_prev = 1'b0;
        if (mq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_mem_access actual_addr=0x%08h required=no_access", mem_addr);
        end else begin
          e = mq.pop_front();
          chk("mem_addr", mem_addr, e.addr);
          chk("mem_we", {31'd0, mem_we}, {31'd0, e.we});
          if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
        end
        if (mem_we) mem[mem_addr[9:0]] = mem_wdata;
        mem_rdata = mem[mem_addr[9:0]];
      end else begin
        mem_ready = 1'b0;
        wcnt++;
        have_prev  = 1'b1;
        prev_addr  = mem_addr;
        prev_we    = mem_we;
        prev_wdata = mem_wdata;
      end
    end else begin
      mem_ready = spurious;
      wcnt = 0;
      have_prev = 1'b0;
      if (mem_we) chk("we_without_req", {31'd0, mem_we}, 32'd0);
    end
  end

  // Completion monitor.
  always @(negedge clk) begin
    done_t e;
    if (!rst && done) begin
      if (dq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual_err=%0d SP=%0d required=no_done", err, SP);
      end else begin
        e = dq.pop_front();
        chk("done_err", {31'd0, err}, {31'd0, e.err});
        chk("done_SP", SP, e.sp);
        chk("done_LMD", LMD, e.lmd);
        chk("done_busy", {31'd0, busy}, 32'd1);
      end
    end
  end

  task automatic do_op(input logic [2:0] op, input logic [31:0] pc, input logic [31:0] val,
                       input int waits, input logic poke, input int exp_lat);
    int   n;
    logic got;
    wait_n = waits;
    @(posedge clk); #1;
    start = 1'b1; StackOp = op; PCin = pc; regval = val;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    got = 1'b0;
    while (!got && n < 50) begin
      @(negedge clk);
      n++;
      if (done) got = 1'b1;
      else if (poke && n == 1) begin start = 1'b1; StackOp = 3'b001; end
      else if (poke && n == 2) start = 1'b0;
    end
    start = 1'b0;
    checks++;
    if (!got || n != exp_lat) begin
      failures++;
      $display("FAIL latency op=%0d actual=%0d required=%0d", op, got ? n : -1, exp_lat);
    end
    @(posedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; StackOp = 3'b001; PCin = 32'd0; regval = 32'd1;
    mem_ready = 1'b0; mem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_SP", SP, 32'd1023);
    chk("rst_LMD", LMD, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_flags", {29'd0, busy, done, err}, 32'd0);

    exp_mem(32'd1023, 1'b1, 32'hDEADBEEF); exp_done(1'b0, 32'd1022, 32'd0);
    do_op(3'b001, 32'd0, 32'hDEADBEEF, 0, 1'b0, 2);
    exp_mem(32'd1023, 1'b0, 32'd0); exp_done(1'b0, 32'd1023, 32'hDEADBEEF);
    do_op(3'b010, 32'd0, 32'd0, 3, 1'b1, 5);
    exp_mem(32'd1023, 1'b1, 32'd41); exp_done(1'b0, 32'd1022, 32'hDEADBEEF);
    do_op(3'b011, 32'd40, 32'd0, 1, 1'b0, 3);
    exp_mem(32'd1023, 1'b0, 32'd0); exp_done(1'b0, 32'd1023, 32'd41);
    do_op(3'b100, 32'd0, 32'd0, 0, 1'b0, 2);
    exp_done(1'b1, 32'd1023, 32'd41);
    do_op(3'b010, 32'd0, 32'd0, 0, 1'b0, 1);
    exp_done(1'b1, 32'd1023, 32'd41);
    do_op(3'b100, 32'd0, 32'd0, 0, 1'b0, 1);

    spurious = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      start = 1'b1;
      StackOp = (k == 0) ? 3'b000 : 3'(k + 4);
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("bad_op_busy", {31'd0, busy}, 32'd0);
      chk("bad_op_SP", SP, 32'd1023);
    end
    spurious = 1'b0;

    exp_mem(32'd1023, 1'b1, 32'd0); exp_done(1'b0, 32'd1022, 32'd41);
    do_op(3'b011, 32'hFFFFFFFF, 32'd0, 0, 1'b0, 2);
    exp_mem(32'd1023, 1'b0, 32'd0); exp_done(1'b0, 32'd1023, 32'd0);
    do_op(3'b100, 32'd0, 32'd0, 2, 1'b0, 4);

    for (int i = 0; i < 256; i++) begin
      exp_mem(32'd1023 - 32'(i), 1'b1, 32'd100 + 32'(i));
      exp_done(1'b0, 32'd1022 - 32'(i), 32'd0);
      do_op(3'b001, 32'd0, 32'd100 + 32'(i), 0, 1'b0, 2);
    end
    exp_done(1'b1, 32'd767, 32'd0);
    do_op(3'b001, 32'd0, 32'd999, 0, 1'b0, 1);
    exp_done(1'b1, 32'd767, 32'd0);
    do_op(3'b011, 32'd5, 32'd0, 0, 1'b0, 1);
    exp_mem(32'd768, 1'b0, 32'd0); exp_done(1'b0, 32'd768, 32'd355);
    do_op(3'b010, 32'd0, 32'd0, 1, 1'b0, 3);

    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_mem(32'd1023 - 32'(i), 1'b1, 32'(i + 1));
      exp_done(1'b0, 32'd1022 - 32'(i), 32'd0);
      do_op(3'b001, 32'd0, 32'(i + 1), 0, 1'b0, 2);
    end
    wait_n = 10;
    @(posedge clk); #1;
    start = 1'b1; StackOp = 3'b001; regval = 32'd77;
    @(posedge clk); #1;
    StackOp = 3'b010;
    @(negedge clk);
    chk("abort_mem_req", {31'd0, mem_req}, 32'd1);
    chk("abort_mem_addr", mem_addr, 32'd1020);
    @(posedge clk); #1;
    start = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_mem_req_after", {31'd0, mem_req}, 32'd0);
    chk("abort_SP", SP, 32'd1023);
    chk("abort_LMD", LMD, 32'd0);
    chk("abort_done", {30'd0, done, busy}, 32'd0);
    wait_n = 0;
    exp_mem(32'd1023, 1'b1, 32'd9); exp_done(1'b0, 32'd1022, 32'd0);
    do_op(3'b001, 32'd0, 32'd9, 0, 1'b0, 2);

    repeat (4) @(negedge clk);
    chk("done_queue_empty", 32'(dq.size()), 32'd0);
    chk("mem_queue_empty", 32'(mq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
